lcd_arbiter: RTL and testbench
==============================

LCD_ARBITER -- requirements
Module: lcd_arbiter

Interface
REQ-001 Parameter: CMD_W, default 10, width of an LCD bus word {rs, rw, data[7:0]}.
REQ-002 Parameter: TIMEOUT, default 1023, maximum cycles a grant may stay in ISSUE+WAIT before abort.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: req0 / req1  input  1  request from requester 0 / 1.
REQ-006 Port: cmd0 / cmd1  input  CMD_W  command word from requester 0 / 1.
REQ-007 Port: gnt0 / gnt1  output  1  one-cycle registered grant pulse.
REQ-008 Port: done0 / done1  output  1  one-cycle registered completion pulse.
REQ-009 Port: lcd_busy  input  1  busy flag from the LCD controller.
REQ-010 Port: lcd_enable  output  1  transfer strobe to the LCD controller.
REQ-011 Port: lcd_bus  output  CMD_W  command word to the LCD controller.
REQ-012 Port: err  output  1  one-cycle timeout pulse; constant 0 when timeout is compiled out.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT; only one transfer SHALL be outstanding.
REQ-014 IDLE: if lcd_busy=0 and any req is high, the arbiter SHALL latch the winner's cmd, pulse its gnt in the next cycle, and enter ISSUE on the same edge.
REQ-015 IDLE with lcd_busy=1 SHALL grant nothing, even with pending requests.
REQ-016 Arbitration SHALL be round-robin: single request wins; on simultaneous requests, the requester not served last wins.
REQ-017 ISSUE: lcd_enable=1 and lcd_bus=latched cmd; the FSM SHALL hold ISSUE until lcd_busy=1 is sampled, then enter WAIT.
REQ-018 WAIT: lcd_enable=0 and lcd_bus SHALL hold the latched cmd; on sampling lcd_busy=0 the FSM SHALL pulse the owner's done and enter IDLE.
REQ-019 The last-served pointer SHALL update only when done is pulsed.
REQ-020 Requesters SHALL hold req and cmd stable until gnt; req still high in the cycle after gnt SHALL NOT produce a second grant before done.
REQ-021 Request changes during ISSUE/WAIT SHALL NOT affect lcd_bus or the owner.
REQ-022 At most one of gnt0/gnt1 and at most one of done0/done1 SHALL be high in any cycle.
REQ-023 Minimum grant-to-done latency SHALL be 3 cycles (gnt, busy seen high, busy seen low).
REQ-024 lcd_bus SHALL be 0 in IDLE.

Reset
REQ-025 With rst_n=0 at a rising edge: state=IDLE; gnt*, done*, lcd_enable, lcd_bus, err=0; pointer set so req0 wins the first tie; timeout counter=0.
REQ-026 Reset asserted during ISSUE/WAIT SHALL abort the transfer with no done pulse.

Configuration
REQ-027 Macro LCD_ARBITER_TIMEOUT_EN defined: a counter SHALL run in ISSUE+WAIT; on reaching TIMEOUT it SHALL pulse err and the owner's done in the same cycle, update the pointer, and return to IDLE.
REQ-028 Macro undefined: no counter, err tied 0, the FSM SHALL wait indefinitely for lcd_busy.

Structure
REQ-029 Package lcd_arbiter_pkg SHALL hold the state enum, the CMD_W default and the lcd_bus field positions (RS=9, RW=8, DATA=7:0).
REQ-030 Round-robin selection SHALL be a sub-module lcd_arbiter_rr (inputs req[1:0] and last; outputs one-hot pick).

Verification
REQ-031 Single request: req0=1, cmd0=10'h238, lcd_busy=0 -> gnt0 next cycle, lcd_bus=10'h238 with lcd_enable=1 until busy=1, done0 one cycle after busy falls.
REQ-032 Tie: req0=req1=1 from reset -> req0 served first, then req1; lcd_bus=cmd1 on the second grant.
REQ-033 Busy block: lcd_busy=1 held 20 cycles with req1=1 -> no gnt1 until the cycle after busy falls.
REQ-034 Reset in WAIT: rst_n=0 one cycle -> all outputs 0, no done, next tie goes to req0.
REQ-035 Timeout (macro defined, TIMEOUT=8): busy stuck at 1 after issue -> err and done pulsed 8 cycles after gnt, FSM in IDLE.
REQ-036 Stable request: req0 held high for 3 transfers, busy toggled -> exactly one gnt0 per done0, never two grants outstanding.

Source files
------------

// File: rtl/lcd_arbiter_pkg.sv
// Shared types and constants for the two-requester LCD command arbiter.
// Holds the FSM state encoding, the default bus word width and its field layout.
package lcd_arbiter_pkg;

   localparam int unsigned CMD_W_DEF = 10;
   localparam int unsigned N_REQ     = 2;

   // Field positions inside an LCD bus word {rs, rw, data[7:0]}
   localparam int unsigned RS_BIT   = 9;
   localparam int unsigned RW_BIT   = 8;
   localparam int unsigned DATA_MSB = 7;
   localparam int unsigned DATA_LSB = 0;

   typedef struct packed {
      logic       rs;
      logic       rw;
      logic [7:0] data;
   } lcd_word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

endpackage

// File: rtl/lcd_arbiter_rr.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the
// requester that was not served last. Purely combinational one-hot output.
module lcd_arbiter_rr
   import lcd_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic             last,
   output logic [N_REQ-1:0] pick
);

   always_comb begin
      pick = '0;
      case (req)
         2'b01:   pick = 2'b01;
         2'b10:   pick = 2'b10;
         2'b11:   pick = last ? 2'b01 : 2'b10;
         default: pick = '0;
      endcase
   end

endmodule

// File: rtl/lcd_arbiter.sv
// Arbitrates two command requesters onto a single LCD controller, one transfer at a time.
// Define LCD_ARBITER_TIMEOUT_EN to abort transfers that stay outstanding for TIMEOUT cycles.
module lcd_arbiter
   import lcd_arbiter_pkg::*;
#(
   parameter int unsigned CMD_W   = CMD_W_DEF,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [CMD_W-1:0] cmd0,
   input  logic [CMD_W-1:0] cmd1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   input  logic             lcd_busy,
   output logic             lcd_enable,
   output logic [CMD_W-1:0] lcd_bus,
   output logic             err
);

   state_t           state, state_nxt;
   logic             owner, owner_nxt;
   logic             last, last_nxt;
   logic [N_REQ-1:0] pick, gnt_nxt, done_nxt;
   logic             enable_nxt;
   logic [CMD_W-1:0] bus_nxt;

`ifdef LCD_ARBITER_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             err_nxt;
`endif

   lcd_arbiter_rr u_rr (
      .req  ({req1, req0}),
      .last (last),
      .pick (pick)
   );

   // State and registered outputs; lcd_bus doubles as the latched command
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last       <= 1'b1;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         done0      <= 1'b0;
         done1      <= 1'b0;
         lcd_enable <= 1'b0;
         lcd_bus    <= '0;
`ifdef LCD_ARBITER_TIMEOUT_EN
         cnt        <= '0;
         err        <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last       <= last_nxt;
         gnt0       <= gnt_nxt[0];
         gnt1       <= gnt_nxt[1];
         done0      <= done_nxt[0];
         done1      <= done_nxt[1];
         lcd_enable <= enable_nxt;
         lcd_bus    <= bus_nxt;
`ifdef LCD_ARBITER_TIMEOUT_EN
         cnt        <= cnt_nxt;
         err        <= err_nxt;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      last_nxt   = last;
      gnt_nxt    = '0;
      done_nxt   = '0;
      enable_nxt = 1'b0;
      bus_nxt    = lcd_bus;
`ifdef LCD_ARBITER_TIMEOUT_EN
      cnt_nxt    = '0;
      err_nxt    = 1'b0;
`endif
      case (state)
         IDLE: begin
            bus_nxt = '0;
            if (!lcd_busy && (pick != '0)) begin
               state_nxt  = ISSUE;
               owner_nxt  = pick[1];
               gnt_nxt    = pick;
               enable_nxt = 1'b1;
               bus_nxt    = pick[1] ? cmd1 : cmd0;
            end
         end
         ISSUE: begin
            if (lcd_busy) state_nxt = WAIT;
            else          enable_nxt = 1'b1;
         end
         WAIT: begin
            if (!lcd_busy) begin
               state_nxt = IDLE;
               done_nxt  = owner ? 2'b10 : 2'b01;
               last_nxt  = owner;
               bus_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            bus_nxt   = '0;
         end
      endcase
`ifdef LCD_ARBITER_TIMEOUT_EN
      // Abort overrides normal completion once the grant has aged TIMEOUT cycles
      if (state != IDLE) begin
         if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state_nxt  = IDLE;
            enable_nxt = 1'b0;
            bus_nxt    = '0;
            done_nxt   = owner ? 2'b10 : 2'b01;
            last_nxt   = owner;
            err_nxt    = 1'b1;
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
         end
      end
`endif
   end

`ifndef LCD_ARBITER_TIMEOUT_EN
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_arbiter.sv
// Self-checking bench for lcd_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_lcd_arbiter;

   localparam int unsigned CMD_W = 10;
   localparam int unsigned TMO   = 8;
`ifdef LCD_ARBITER_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n, req0, req1, lcd_busy;
   logic [CMD_W-1:0] cmd0, cmd1;
   logic             gnt0, gnt1, done0, done1, lcd_enable, err;
   logic [CMD_W-1:0] lcd_bus;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: active = owner index of the outstanding transfer, -1 if none
   int               m_active, m_last, m_age;
   bit               m_seen;
   logic [CMD_W-1:0] e_bus;
   bit               e_en, e_g0, e_g1, e_d0, e_d1, e_err;

   always #5 clk = ~clk;

   lcd_arbiter #(.CMD_W(CMD_W), .TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0       (req0),
      .req1       (req1),
      .cmd0       (cmd0),
      .cmd1       (cmd1),
      .gnt0       (gnt0),
      .gnt1       (gnt1),
      .done0      (done0),
      .done1      (done1),
      .lcd_busy   (lcd_busy),
      .lcd_enable (lcd_enable),
      .lcd_bus    (lcd_bus),
      .err        (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic finish_xfer(input bit timed_out);
      if (m_active == 0) e_d0 = 1'b1;
      else               e_d1 = 1'b1;
      e_err    = timed_out;
      m_last   = m_active;
      m_active = -1;
      e_bus    = '0;
      e_en     = 1'b0;
   endtask

   // One clock edge of the spec's behaviour, using the inputs the DUT samples
   task automatic model_edge();
      int win;
      e_g0 = 0; e_g1 = 0; e_d0 = 0; e_d1 = 0; e_err = 0;
      if (!rst_n) begin
         m_active = -1; m_last = 1; m_age = 0; m_seen = 0;
         e_bus = '0; e_en = 0;
      end else if (m_active < 0) begin
         e_bus = '0; e_en = 0;
         if (!lcd_busy && (req0 || req1)) begin
            if (req0 && req1) win = (m_last == 0) ? 1 : 0;
            else              win = req1 ? 1 : 0;
            m_active = win; m_seen = 0; m_age = 0;
            e_bus = win ? cmd1 : cmd0;
            e_en  = 1'b1;
            if (win == 0) e_g0 = 1'b1;
            else          e_g1 = 1'b1;
         end
      end else begin
         m_age++;
         if (TMO_EN && m_age == TMO) finish_xfer(1'b1);
         else if (!m_seen) begin
            if (lcd_busy) begin m_seen = 1; e_en = 0; end
         end else if (!lcd_busy) finish_xfer(1'b0);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("ctrl", 32'({err, done1, done0, gnt1, gnt0, lcd_enable}),
                    32'({e_err, e_d1, e_d0, e_g1, e_g0, e_en}));
      check("bus", 32'(lcd_bus), 32'(e_bus));
   endtask

   initial begin
      rst_n = 0; req0 = 0; req1 = 0; cmd0 = '0; cmd1 = '0; lcd_busy = 0;
      step(); step();
      check("rst_outputs", 32'({gnt0, gnt1, done0, done1, lcd_enable, err, lcd_bus}), 32'd0);
      rst_n = 1;

      // Single request
      req0 = 1; cmd0 = 10'h238;
      step();
      check("single_gnt0", 32'(gnt0), 32'd1);
      check("single_bus", 32'(lcd_bus), 32'h238);
      req0 = 0;
      step(); step();
      check("single_en_hold", 32'(lcd_enable), 32'd1);
      lcd_busy = 1; step();
      check("single_wait_en", 32'(lcd_enable), 32'd0);
      check("single_wait_bus", 32'(lcd_bus), 32'h238);
      lcd_busy = 0; step();
      check("single_done0", 32'(done0), 32'd1);
      step();

      // Tie from reset: req0 first, then req1
      rst_n = 0; step(); rst_n = 1;
      req0 = 1; req1 = 1; cmd0 = 10'h101; cmd1 = 10'h2a5;
      step();
      check("tie_first_gnt0", 32'({gnt1, gnt0}), 32'b01);
      req0 = 0; lcd_busy = 1; step();
      lcd_busy = 0; step();
      check("tie_done0", 32'(done0), 32'd1);
      step();
      check("tie_second_gnt1", 32'({gnt1, gnt0}), 32'b10);
      check("tie_second_bus", 32'(lcd_bus), 32'h2a5);
      req1 = 0; lcd_busy = 1; step();
      lcd_busy = 0; step();
      check("tie_done1", 32'(done1), 32'd1);
      step();

      // Busy blocks granting
      lcd_busy = 1; req1 = 1; cmd1 = 10'h03c;
      for (int i = 0; i < 20; i++) begin
         step();
         check("busy_no_gnt1", 32'(gnt1), 32'd0);
      end
      lcd_busy = 0; step();
      check("busy_gnt1_after", 32'(gnt1), 32'd1);
      req1 = 0; lcd_busy = 1; step();

      // Reset while waiting aborts silently; next tie goes to req0
      rst_n = 0; step();
      check("rstwait_outputs", 32'({gnt0, gnt1, done0, done1, lcd_enable, err, lcd_bus}), 32'd0);
      rst_n = 1; lcd_busy = 0; req0 = 1; req1 = 1; step();
      check("rstwait_tie_gnt0", 32'({gnt1, gnt0}), 32'b01);
      req0 = 0; req1 = 0; lcd_busy = 1; step();
      lcd_busy = 0; step();
      check("rstwait_done0", 32'(done0), 32'd1);
      step();

      // Busy stuck high after issue
      req1 = 1; cmd1 = 10'h155; step();
      check("stuck_gnt1", 32'(gnt1), 32'd1);
      req1 = 0; lcd_busy = 1;
      for (int i = 1; i < int'(TMO); i++) begin
         step();
         check("stuck_no_done", 32'({err, done1}), 32'd0);
      end
      step();
`ifdef LCD_ARBITER_TIMEOUT_EN
      check("timeout_err_done", 32'({err, done1}), 32'b11);
      lcd_busy = 0; step();
      check("timeout_idle_bus", 32'(lcd_bus), 32'd0);
`else
      check("no_timeout_wait", 32'({err, done1}), 32'b00);
      lcd_busy = 0; step();
      check("late_done1", 32'(done1), 32'd1);
`endif
      step();

      // Held request: one grant per completion
      req0 = 1; cmd0 = 10'h0a7;
      for (int i = 0; i < 3; i++) begin
         step();
         check("held_gnt0", 32'(gnt0), 32'd1);
         lcd_busy = 1; step();
         check("held_no_regnt", 32'(gnt0), 32'd0);
         lcd_busy = 0; step();
         check("held_done0", 32'(done0), 32'd1);
      end
      req0 = 0; step();

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst_n    = ($urandom_range(0, 299) != 0);
         req0     = ($urandom_range(0, 2) != 0);
         req1     = ($urandom_range(0, 2) != 0);
         cmd0     = CMD_W'($urandom);
         cmd1     = CMD_W'($urandom);
         lcd_busy = ($urandom_range(0, 9) < 4);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
